cabac_bit_feeder: RTL

Sequential, parametrised bit-consumption tracker and byte feeder for the VVC CABAC arithmetic decoder. It owns the `m_bitsNeeded` register and prefetches bitstream bytes into a small FIFO. It services one consume request per cycle: a regular-bin LPS renorm, a regular-bin MPS renorm, or a multi-bin bypass. When a request crosses a byte boundary, it delivers the next byte to the value register and stalls the decoder if no byte is buffered.

---
 rtl/cabac_pkg.sv | 21 ++
 rtl/cabac_byte_fifo.sv | 47 ++++
 rtl/cabac_bit_feeder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cabac_pkg.sv
// Shared types and constants for the CABAC bit feeder.
// Consume-mode and FSM-state enums, bits_needed init value, byte width.
package cabac_pkg;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        LPS    = 2'd1,
        MPS_RN = 2'd2,
        BYPASS = 2'd3
    } cons_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } fsm_state_e;

    localparam logic signed [3:0] BN_INIT = 4'sb1000;
    localparam int BYTE_BITS = 8;

endpackage

// File: rtl/cabac_byte_fifo.sv
// Synchronous byte FIFO, no write-through; head is always visible on dout.
// Ports: push/din write side, pop/dout read side, empty/full status.
module cabac_byte_fifo
    import cabac_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [BYTE_BITS-1:0] din,
    output logic [BYTE_BITS-1:0] dout,
    output logic                 empty,
    output logic                 full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]          wr_q;
    logic [AW:0]          rd_q;
    logic [BYTE_BITS-1:0] mem_q [DEPTH];
    logic                 do_push;
    logic                 do_pop;

    // Extra pointer MSB distinguishes full from empty.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cabac_bit_feeder.sv
// CABAC m_bitsNeeded tracker and byte feeder with prefetch FIFO.
// Ports: start, bs_* byte input, cons_* requests, byte_out*, init_done,
// bits_needed; bytes_consumed when CABAC_BIT_FEEDER_STATS_EN is defined.
module cabac_bit_feeder
    import cabac_pkg::*;
#(
    parameter int MAX_BYPASS_BINS = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int INIT_BYTES      = 3,
    localparam int NB_W = (MAX_BYPASS_BINS > 1) ?
                          $clog2(MAX_BYPASS_BINS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BYTE_BITS-1:0] bs_data,
    input  logic                 bs_valid,
    output logic                 bs_ready,
    input  logic                 cons_valid,
    output logic                 cons_ready,
    input  logic [1:0]           cons_mode,
    input  logic [2:0]           num_bits,
    input  logic [NB_W-1:0]      n_bins,
    output logic [BYTE_BITS-1:0] byte_out,
    output logic                 byte_out_valid,
    output logic                 init_done,
    output logic signed [3:0]    bits_needed
`ifdef CABAC_BIT_FEEDER_STATS_EN
    ,
    output logic [31:0]          bytes_consumed
`endif
);

    fsm_state_e          state_q, state_d;
    logic [2:0]          init_cnt_q, init_cnt_d;
    logic signed [3:0]   bn_q, bn_d;
    logic                init_done_q;
    logic                fifo_push, fifo_pop;
    logic                fifo_empty, fifo_full;
    logic [BYTE_BITS-1:0] fifo_dout;
    logic [3:0]          shift;
    logic signed [3:0]   sum;
    logic                need_byte;

    cabac_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bs_data),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign fifo_push = bs_valid && !fifo_full;
    assign bs_ready  = !fifo_full;

    // A shift of 8 (bypass of 8 bins) wraps to -8 in 4 bits; the
    // modulo-16 sum is still correct for bits_needed in -8..-1.
    always_comb begin
        shift = 4'd0;
        unique case (cons_mode_e'(cons_mode))
            LPS, MPS_RN: shift = {1'b0, num_bits};
            BYPASS:      shift = 4'(n_bins) + 4'd1;
            default:     shift = 4'd0;
        endcase
        sum       = bn_q + $signed(shift);
        need_byte = (cons_mode_e'(cons_mode) != NONE) && !sum[3];
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        bn_d       = bn_q;
        fifo_pop   = 1'b0;
        cons_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = INIT;
                    init_cnt_d = 3'(INIT_BYTES);
                end
            end
            INIT: begin
                if (start) begin
                    init_cnt_d = 3'(INIT_BYTES);
                    bn_d       = BN_INIT;
                end else if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    init_cnt_d = init_cnt_q - 3'd1;
                    if (init_cnt_q == 3'd1) begin
                        state_d = RUN;
                        bn_d    = BN_INIT;
                    end
                end
            end
            RUN: begin
                if (start) begin
                    // Restart drops the request in flight.
                    state_d    = INIT;
                    init_cnt_d = 3'(INIT_BYTES);
                    bn_d       = BN_INIT;
                end else begin
                    cons_ready = !(need_byte && fifo_empty);
                    if (cons_valid && cons_ready) begin
                        fifo_pop = need_byte;
                        // Adding -8 is subtracting one byte of bits.
                        bn_d = need_byte ? sum + BN_INIT : sum;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_out_valid = fifo_pop;
    assign byte_out       = fifo_pop ? fifo_dout : '0;
    assign init_done      = init_done_q;
    assign bits_needed    = bn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            init_cnt_q  <= 3'd0;
            bn_q        <= BN_INIT;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            bn_q        <= bn_d;
            init_done_q <= (state_d == RUN);
        end
    end

`ifdef CABAC_BIT_FEEDER_STATS_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (fifo_pop && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bytes_consumed = cnt_q;
`endif

endmodule
